multdiv_ctrl: RTL
=================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: ctrl_MULT  input  1  one-cycle pulse; start signed multiply.
REQ-006 Port: ctrl_DIV  input  1  one-cycle pulse; start signed divide.
REQ-007 Port: data_operandA  input  32  multiplicand/dividend; sampled only on a start edge.
REQ-008 Port: data_operandB  input  32  multiplier/divisor; sampled only on a start edge.
REQ-009 Port: data_result  output  32  registered result; valid while data_resultRDY=1.
REQ-010 Port: data_exception  output  1  registered; valid while data_resultRDY=1.
REQ-011 Port: data_resultRDY  output  1  one-cycle completion strobe.
REQ-012 Port: data_busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, SETUP, RUN, FIX and DONE.
REQ-014 Start: the sampling edge SHALL be any edge with exactly one of ctrl_MULT/ctrl_DIV high; it latches operands and the op, and enters SETUP.
REQ-015 Both ctrl inputs high SHALL be ignored: no start and no state change.
REQ-016 SETUP (1 cycle) SHALL record sign(A) XOR sign(B), replace each negative operand by its magnitude (invert, then +1), and clear the counter.
REQ-017 RUN SHALL last exactly 32 cycles: one shift-add multiply step or one restoring-divide step per cycle; the counter wraps 31->0 on exit to FIX.
REQ-018 FIX (1 cycle) SHALL negate the magnitude result when the recorded sign is 1, compute the exception, and register data_result/data_exception.
REQ-019 Latency: data_resultRDY SHALL rise on the 34th rising edge after the sampling edge and stay high exactly 1 cycle (DONE), then return to IDLE.
REQ-020 Multiply result SHALL be the low 32 bits of the 64-bit signed product.
REQ-021 Multiply exception SHALL be 1 when the signed product does not fit in 32 bits.
REQ-022 Divide result SHALL be the quotient truncated toward zero; the remainder is discarded.
REQ-023 Divisor 0 SHALL give result 0 and exception 1, at the same latency.
REQ-024 Divide 0x80000000 / -1 SHALL give result 0 and exception 1.
REQ-025 A valid start in SETUP/RUN/FIX/DONE SHALL abort the current op with no strobe, reload the operands and restart timing from that edge.
REQ-026 data_result and data_exception SHALL hold their last values outside DONE until the next FIX.

Reset
REQ-027 reset_n low SHALL force IDLE immediately, regardless of clock, from any state.
REQ-028 Reset SHALL clear the counter, data_result (0), data_exception (0), data_resultRDY (0) and data_busy (0).
REQ-029 An operation interrupted by reset SHALL never produce a strobe; the first edge after release may sample a start.

Structure
REQ-030 A shared package SHALL hold the state encoding, WIDTH and the iteration-count constant (32).
REQ-031 Sub-module negate32 (bitwise invert plus increment, 32-bit) SHALL be instantiated for both SETUP magnitudes and the FIX sign correction.

Verification
REQ-032 MULT 7 x 0xFFFFFFFA -> result 0xFFFFFFD6, exception 0, RDY on edge 34 after the sampling edge.
REQ-033 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; DIV 5 / 0 -> result 0, exception 1.
REQ-035 MULT 3x4, then DIV 100/7 pulsed 10 cycles later -> single RDY 34 edges after the DIV pulse, result 14, exception 0.
REQ-036 reset_n low during RUN -> outputs 0, data_busy 0 at once, no RDY; a new MULT 2x2 after release -> 4.
REQ-037 ctrl_MULT and ctrl_DIV high together in IDLE -> data_busy stays 0, no RDY ever.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants, state encoding and op encoding for the sequential signed multiply/divide unit.
package multdiv_ctrl_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } md_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

endpackage

// File: rtl/multdiv_ctrl_negate32.sv
// Two's-complement negation: bitwise invert plus one.
module negate32
    import multdiv_ctrl_pkg::*;
(
    input  logic [MD_WIDTH-1:0] i_a,
    output logic [MD_WIDTH-1:0] o_y
);

    assign o_y = ~i_a + MD_WIDTH'(1);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequential 32-bit signed multiply / divide: sign-magnitude setup, 32 shift-add or
// restoring-divide steps, then sign fix-up with a one-cycle completion strobe.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    md_state_e              r_state;
    md_op_e                 r_op;
    logic [WIDTH-1:0]       r_opa;
    logic [WIDTH-1:0]       r_opb;
    logic [WIDTH-1:0]       r_a;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_sign;
    logic [MD_CNT_W-1:0]    r_cnt;

    logic                   w_start;
    logic [WIDTH-1:0]       w_neg_a;
    logic [WIDTH-1:0]       w_neg_b;
    logic [WIDTH-1:0]       w_neg_q;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH-1:0]       w_diff;
    logic                   w_ge;
    logic [2*WIDTH-1:0]     w_mul_step;
    logic [2*WIDTH-1:0]     w_div_step;
    logic [WIDTH-1:0]       w_signed_q;
    logic                   w_mul_ovf;
    logic [WIDTH-1:0]       w_fix_result;
    logic                   w_fix_exc;

    // Exactly one control high is a start; both high is treated as no request.
    assign w_start = ctrl_MULT ^ ctrl_DIV;

    negate32 u_neg_a   (.i_a(r_opa),            .o_y(w_neg_a));
    negate32 u_neg_b   (.i_a(r_opb),            .o_y(w_neg_b));
    negate32 u_neg_fix (.i_a(r_acc[WIDTH-1:0]), .o_y(w_neg_q));

    assign w_mag_a = r_opa[WIDTH-1] ? w_neg_a : r_opa;
    assign w_mag_b = r_opb[WIDTH-1] ? w_neg_b : r_opb;

    // r_acc holds {partial product, multiplier} or {remainder, quotient/dividend}.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_a});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_a;
    assign w_div_step = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // A negative product may reach -2^31; a positive one must stay below 2^31.
    assign w_signed_q = r_sign ? w_neg_q : r_acc[WIDTH-1:0];
    assign w_mul_ovf  = r_sign ? ((|r_acc[2*WIDTH-1:WIDTH]) || (r_acc[WIDTH-1] && (|r_acc[WIDTH-2:0])))
                               : (|r_acc[2*WIDTH-1:WIDTH-1]);

    always_comb begin
        w_fix_result = w_signed_q;
        w_fix_exc    = 1'b0;
        if (r_op == OP_MUL) begin
            w_fix_exc = w_mul_ovf;
        end else if ((r_a == '0) || (!r_sign && r_acc[WIDTH-1])) begin
            w_fix_result = '0;
            w_fix_exc    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_MUL;
            r_opa          <= '0;
            r_opb          <= '0;
            r_a            <= '0;
            r_acc          <= '0;
            r_sign         <= 1'b0;
            r_cnt          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            data_busy      <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (w_start) begin
                r_state   <= ST_SETUP;
                r_op      <= ctrl_DIV ? OP_DIV : OP_MUL;
                r_opa     <= data_operandA;
                r_opb     <= data_operandB;
                data_busy <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        data_busy <= 1'b0;
                    end
                    ST_SETUP: begin
                        r_sign  <= r_opa[WIDTH-1] ^ r_opb[WIDTH-1];
                        r_cnt   <= '0;
                        r_a     <= (r_op == OP_MUL) ? w_mag_a : w_mag_b;
                        r_acc   <= {{WIDTH{1'b0}}, ((r_op == OP_MUL) ? w_mag_b : w_mag_a)};
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        r_acc <= (r_op == OP_MUL) ? w_mul_step : w_div_step;
                        r_cnt <= r_cnt + MD_CNT_W'(1);
                        if (r_cnt == MD_CNT_W'(MD_ITER - 1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        data_result    <= w_fix_result;
                        data_exception <= w_fix_exc;
                        data_resultRDY <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                    ST_DONE: begin
                        data_busy <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                    default: begin
                        data_busy <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
